// File: rtl/mem_pkg.sv
// Shared types for the multi-cycle memory controller:
// phase states, address regions, region decode and default widths.
package mem_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_SRAM_AW = 12;
    localparam int DEF_EXT_AW  = 27;

    typedef enum logic [1:0] {
        FETCH,
        FWAIT,
        EXEC,
        DWAIT
    } state_t;

    typedef enum logic [1:0] {
        RG_SRAM,
        RG_EXT,
        RG_ERR
    } region_t;

    // Low words live in the SRAM bank, the next 2**ext_aw words
    // on the external port, anything above is unmapped.
    function automatic region_t decode(
        input logic [29:0] a,
        input int          sram_aw,
        input int          ext_aw
    );
        logic [32:0] w;
        logic [32:0] depth;
        logic [32:0] lim;
        w     = {3'b000, a};
        depth = 33'd1 << sram_aw;
        lim   = depth + (33'd1 << ext_aw);
        if (w < depth) return RG_SRAM;
        if (w < lim) return RG_EXT;
        return RG_ERR;
    endfunction

endpackage

// File: rtl/mem_sram_bank.sv
// Single-port synchronous SRAM bank, DATA_W x 2**AW, 1-cycle read.
// Ports: clk, en, we, addr, wdata, [be], q. Macro: MEM_BYTE_MASK_EN.
module mem_sram_bank
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AW     = DEF_SRAM_AW
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
`ifdef MEM_BYTE_MASK_EN
    input  logic [DATA_W/8-1:0] be,
`endif
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
`ifdef MEM_BYTE_MASK_EN
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
`else
                mem[addr] <= wdata;
`endif
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/memory_ctrl_mc.sv
// Multi-cycle I/D memory controller: fetch/exec phases, SRAM + external port.
// Ports: clk, rst_n, next_pc, addr_in, data_in, S, L, [be], I, PC, E, done,
// data_out, err, address, write_data, read_data, read_req, write_req, ready,
// [ext_be]. Macro: MEM_BYTE_MASK_EN adds be/ext_be byte masking.
module memory_ctrl_mc
    import mem_pkg::*;
#(
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int          SRAM_AW  = DEF_SRAM_AW,
    parameter int          EXT_AW   = DEF_EXT_AW,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       next_pc,
    input  logic [29:0]       addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              S,
    input  logic              L,
`ifdef MEM_BYTE_MASK_EN
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W/8-1:0] ext_be,
`endif
    output logic [DATA_W-1:0] I,
    output logic [31:0]       PC,
    output logic              E,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic              err,
    output logic [EXT_AW-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              read_req,
    output logic              write_req,
    input  logic              ready
);

    localparam logic [29:0] SRAM_DEPTH = 30'd1 << SRAM_AW;

    state_t            state, state_nx;
    region_t           rg;
    logic              fetch_ph;
    logic              data_op;
    logic [29:0]       acc_addr;
    logic [29:0]       ext_off;
    logic              sram_en, sram_we;
    logic [DATA_W-1:0] sram_q;
    logic [DATA_W-1:0] fetch_word;
    logic              unused_ok;

    assign fetch_ph = (state == FETCH) || (state == FWAIT);
    assign data_op  = S | L;
    assign acc_addr = fetch_ph ? PC[31:2] : addr_in;
    assign ext_off  = acc_addr - SRAM_DEPTH;
    assign address  = ext_off[EXT_AW-1:0];
    assign unused_ok = ^ext_off[29:EXT_AW];
    assign write_data = data_in;

    // A misaligned PC is treated like an unmapped address.
    always_comb begin
        rg = decode(acc_addr, SRAM_AW, EXT_AW);
        if (fetch_ph && PC[1:0] != 2'b00) rg = RG_ERR;
    end

    always_comb begin
        unique case (rg)
            RG_SRAM: fetch_word = sram_q;
            RG_EXT:  fetch_word = read_data;
            default: fetch_word = '0;
        endcase
    end

`ifdef MEM_BYTE_MASK_EN
    assign ext_be = (!fetch_ph && S) ? be : '1;
`endif

    mem_sram_bank #(
        .DATA_W(DATA_W),
        .AW    (SRAM_AW)
    ) u_sram (
        .clk  (clk),
        .en   (sram_en),
        .we   (sram_we),
        .addr (acc_addr[SRAM_AW-1:0]),
        .wdata(data_in),
`ifdef MEM_BYTE_MASK_EN
        .be   (be),
`endif
        .q    (sram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FETCH: state_nx = FWAIT;
            FWAIT: if (rg != RG_EXT || ready) state_nx = EXEC;
            EXEC: begin
                if (!data_op || (rg == RG_SRAM && S)) state_nx = FETCH;
                else                                  state_nx = DWAIT;
            end
            DWAIT: if (rg != RG_EXT || ready) state_nx = FETCH;
            default: state_nx = FETCH;
        endcase
    end

    // Requests are decoded from state so reset drops them at once.
    always_comb begin
        E         = 1'b0;
        done      = 1'b0;
        read_req  = 1'b0;
        write_req = 1'b0;
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        data_out  = '0;
        unique case (state)
            FETCH: begin
                sram_en  = (rg == RG_SRAM);
                read_req = (rg == RG_EXT);
            end
            FWAIT: read_req = (rg == RG_EXT);
            EXEC: begin
                E = 1'b1;
                if (data_op) begin
                    sram_en   = (rg == RG_SRAM);
                    sram_we   = (rg == RG_SRAM) && S;
                    read_req  = (rg == RG_EXT) && !S;
                    write_req = (rg == RG_EXT) && S;
                end
                done = !data_op || (rg == RG_SRAM && S);
            end
            DWAIT: begin
                E         = 1'b1;
                read_req  = (rg == RG_EXT) && !S;
                write_req = (rg == RG_EXT) && S;
                done      = (rg != RG_EXT) || ready;
                if (L && !S) data_out = fetch_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC  <= RESET_PC;
            I   <= '0;
            err <= 1'b0;
        end else begin
            if (state == FWAIT && state_nx == EXEC) I <= fetch_word;
            if (done) PC <= next_pc;
            if (rg == RG_ERR && (state == FETCH || (state == EXEC && data_op)))
                err <= 1'b1;
        end
    end

endmodule
